// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle FETCH/DECODE/EXEC control FSM that owns the
// program counter, handshakes with instruction memory, latches the fetched
// word, commits pc+4 or a branch/jump target and counts retired instructions.
// A taken transfer to a misaligned target parks the FSM in TRAP; a halt
// request parks it in HALTED. Only rst leaves either of those states.

module pc_sequencer #(
    parameter int OPD_WIDTH = 32,
    parameter int PC_WIDTH  = 12,
    parameter int RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    // instruction memory
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic                 imem_ack,
    input  logic [OPD_WIDTH-1:0] imem_rdata,
    // decoder
    output logic [OPD_WIDTH-1:0] instr,
    output logic                 instr_valid,
    // execute stage
    input  logic                 exec_done,
    input  logic                 branch,
    input  logic                 jump,
    input  logic [OPD_WIDTH-1:0] comp_result,
    input  logic [OPD_WIDTH-1:0] target,
    input  logic                 halt,
    // status
    output logic [PC_WIDTH-1:0]  pc,
    output logic [OPD_WIDTH-1:0] pc_plus4,
    output logic [OPD_WIDTH-1:0] instret,
    output logic                 halted,
    output logic                 misaligned
);

    localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALTED,
        S_TRAP
    } state_e;

    state_e               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [OPD_WIDTH-1:0] instr_q, instr_d;
    logic [OPD_WIDTH-1:0] instret_q, instret_d;

    logic taken;
    logic target_misaligned;
    logic unused_target_hi;

    // A branch is taken only on an exact full-width compare result of 1.
    assign taken             = jump | (branch & (comp_result == OPD_WIDTH'(1)));
    assign target_misaligned = (target[1:0] != 2'b00);
    // Target bits above the PC width cannot address instruction memory.
    assign unused_target_hi  = ^target[OPD_WIDTH-1:PC_WIDTH];

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign instret   = instret_q;
    // Zero-extend before adding so the carry out of the pc is kept here.
    assign pc_plus4  = OPD_WIDTH'(pc_q) + OPD_WIDTH'(4);

    // State, pc, instruction latch and retire counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC_V;
            instr_q   <= '0;
            instret_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, so the update order inside this block is irrelevant.
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        // NOTE: every signal written below gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        instret_d   = instret_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        misaligned  = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                instr_valid = 1'b1;
                state_d     = S_EXEC;
            end

            S_EXEC: begin
                if (exec_done) begin
                    if (taken && target_misaligned) begin
                        // Trap wins over halt; pc and instret stay put.
                        state_d = S_TRAP;
                    end else begin
                        pc_d      = taken ? target[PC_WIDTH-1:0] : pc_q + PC_STEP;
                        instret_d = instret_q + OPD_WIDTH'(1);
                        state_d   = halt ? S_HALTED : S_FETCH;
                    end
                end
            end

            S_HALTED: begin
                halted = 1'b1;
            end

            S_TRAP: begin
                misaligned = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. A per-instruction reference model
// (pc, retire count, latched word, run/halt/trap mode) is advanced with plain
// arithmetic from the architectural rules; every cycle of every instruction is
// compared against it while ignored inputs are driven with random values.

module tb_pc_sequencer;

    localparam int OPD_WIDTH = 32;
    localparam int PC_WIDTH  = 12;
    localparam int PC_SPAN   = 1 << PC_WIDTH;

    logic                 clk;
    logic                 rst;
    logic                 imem_req;
    logic [PC_WIDTH-1:0]  imem_addr;
    logic                 imem_ack;
    logic [OPD_WIDTH-1:0] imem_rdata;
    logic [OPD_WIDTH-1:0] instr;
    logic                 instr_valid;
    logic                 exec_done;
    logic                 branch;
    logic                 jump;
    logic [OPD_WIDTH-1:0] comp_result;
    logic [OPD_WIDTH-1:0] target;
    logic                 halt;
    logic [PC_WIDTH-1:0]  pc;
    logic [OPD_WIDTH-1:0] pc_plus4;
    logic [OPD_WIDTH-1:0] instret;
    logic                 halted;
    logic                 misaligned;

    pc_sequencer #(
        .OPD_WIDTH (OPD_WIDTH),
        .PC_WIDTH  (PC_WIDTH),
        .RESET_PC  (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .branch      (branch),
        .jump        (jump),
        .comp_result (comp_result),
        .target      (target),
        .halt        (halt),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instret     (instret),
        .halted      (halted),
        .misaligned  (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state. mode: 0 = running, 1 = halted, 2 = trapped.
    int unsigned m_pc;
    int unsigned m_instret;
    int unsigned m_instr;
    int          m_mode;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (got === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock; outputs are then sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic randomize_ignored();
        branch      = 1'($urandom);
        jump        = 1'($urandom);
        halt        = 1'($urandom);
        comp_result = $urandom;
        target      = $urandom;
    endtask

    task automatic quiet_inputs();
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        exec_done   = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        halt        = 1'b0;
        comp_result = '0;
        target      = '0;
    endtask

    task automatic check_arch(input string tag);
        check({tag, "_pc"},      64'(pc),         64'(m_pc));
        check({tag, "_instret"}, 64'(instret),    64'(m_instret));
        check({tag, "_req"},     64'(imem_req),   64'(m_mode == 0));
        check({tag, "_halted"},  64'(halted),     64'(m_mode == 1));
        check({tag, "_misal"},   64'(misaligned), 64'(m_mode == 2));
    endtask

    // Asynchronous reset pulse placed between clock edges. ack_hold leaves an
    // ack pending across release so it is taken as a fresh fetch of pc 0.
    task automatic do_reset(input logic ack_hold, input logic [OPD_WIDTH-1:0] rdata);
        #2;
        rst        = 1'b1;
        quiet_inputs();
        imem_ack   = ack_hold;
        imem_rdata = rdata;
        #1;
        m_pc      = 0;
        m_instret = 0;
        m_instr   = 0;
        m_mode    = 0;
        check("rst_pc",       64'(pc),          64'(0));
        check("rst_pc_plus4", 64'(pc_plus4),    64'(4));
        check("rst_instret",  64'(instret),     64'(0));
        check("rst_instr",    64'(instr),       64'(0));
        check("rst_req",      64'(imem_req),    64'(1));
        check("rst_ivalid",   64'(instr_valid), 64'(0));
        check("rst_halted",   64'(halted),      64'(0));
        check("rst_misal",    64'(misaligned),  64'(0));
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One full instruction from the first FETCH cycle through commit.
    task automatic run_instr(input int ack_dly, input int exec_dly,
                             input logic br, input logic jp,
                             input logic [OPD_WIDTH-1:0] comp,
                             input logic [OPD_WIDTH-1:0] tgt,
                             input logic hlt);
        logic [OPD_WIDTH-1:0] word;
        logic                 tk;
        word = $urandom;

        check("fetch_req",    64'(imem_req),  64'(1));
        check("fetch_addr",   64'(imem_addr), 64'(m_pc));
        check("fetch_plus4",  64'(pc_plus4),  64'(m_pc) + 64'(4));

        for (int i = 0; i < ack_dly; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            exec_done  = 1'($urandom);
            randomize_ignored();
            step();
            check("wait_ack_req",    64'(imem_req),    64'(1));
            check("wait_ack_ivalid", 64'(instr_valid), 64'(0));
            check("wait_ack_instr",  64'(instr),       64'(m_instr));
        end

        imem_ack   = 1'b1;
        imem_rdata = word;
        exec_done  = 1'($urandom);
        step();
        m_instr = word;
        check("decode_ivalid", 64'(instr_valid), 64'(1));
        check("decode_req",    64'(imem_req),    64'(0));
        check("decode_instr",  64'(instr),       64'(m_instr));

        imem_ack   = 1'($urandom);
        imem_rdata = $urandom;
        exec_done  = 1'($urandom);
        randomize_ignored();
        step();
        check("exec_ivalid", 64'(instr_valid), 64'(0));
        check("exec_instr",  64'(instr),       64'(m_instr));

        for (int i = 0; i < exec_dly; i++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            exec_done  = 1'b0;
            randomize_ignored();
            step();
            check("wait_exec_pc",     64'(pc),       64'(m_pc));
            check("wait_exec_req",    64'(imem_req), 64'(0));
            check("wait_exec_instr",  64'(instr),    64'(m_instr));
        end

        imem_ack    = 1'($urandom);
        exec_done   = 1'b1;
        branch      = br;
        jump        = jp;
        comp_result = comp;
        target      = tgt;
        halt        = hlt;
        step();
        quiet_inputs();

        tk = jp | (br & (comp == 1));
        if (tk && (tgt % 4) != 0) begin
            m_mode = 2;
        end else begin
            m_pc      = tk ? (tgt % PC_SPAN) : ((m_pc + 4) % PC_SPAN);
            m_instret = m_instret + 1;
            m_mode    = hlt ? 1 : 0;
        end
        check_arch("commit");
        check("commit_instr", 64'(instr), 64'(m_instr));
    endtask

    // Stay in a parked state with random activity on every input.
    task automatic hold(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            exec_done  = 1'($urandom);
            randomize_ignored();
            step();
            check_arch("park");
            check("park_instr", 64'(instr), 64'(m_instr));
        end
        quiet_inputs();
    endtask

    initial begin
        logic [OPD_WIDTH-1:0] word;
        logic [OPD_WIDTH-1:0] comp;
        int                   sel;

        rst = 1'b1;
        quiet_inputs();
        @(negedge clk);

        // Reset release, then three back-to-back sequential instructions.
        do_reset(1'b0, '0);
        check_arch("after_rst");
        for (int i = 0; i < 3; i++) run_instr(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        check("seq_instret", 64'(instret), 64'(3));
        check("seq_pc",      64'(pc),      64'(12));

        // Wait states: ack two cycles late, exec_done three cycles late.
        run_instr(2, 3, 1'b0, 1'b0, 0, 0, 1'b0);

        // Taken branch to 0x40, then compare result 2 falls through.
        run_instr(0, 0, 1'b1, 1'b0, 1, 32'h40, 1'b0);
        check("br_taken_pc", 64'(pc), 64'h40);
        run_instr(1, 0, 1'b1, 1'b0, 2, 32'h80, 1'b0);
        check("br_nt_pc", 64'(pc), 64'h44);

        // Randomized instruction stream with aligned targets.
        for (int n = 0; n < 24; n++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       comp = 0;
                1:       comp = 1;
                2:       comp = 32'h1_0001;
                default: comp = $urandom;
            endcase
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom_range(0, 3) == 0), comp,
                      $urandom & 32'hFFFF_FFFC, 1'b0);
        end

        // Asynchronous reset in EXEC with an ack held over release.
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        step();
        imem_ack = 1'b0;
        step();
        word = $urandom;
        do_reset(1'b1, word);
        check("rst_ack_ivalid", 64'(instr_valid), 64'(1));
        check("rst_ack_instr",  64'(instr),       64'(word));
        check("rst_ack_pc",     64'(pc),          64'(0));
        m_instr  = word;
        imem_ack = 1'b0;
        step();
        exec_done = 1'b1;
        step();
        quiet_inputs();
        m_pc      = 4;
        m_instret = 1;
        check_arch("rst_ack_commit");

        // Misaligned jump with halt: trap wins, nothing commits.
        run_instr(0, 1, 1'b0, 1'b1, 0, 32'h42, 1'b1);
        check("trap_halted", 64'(halted),     64'(0));
        check("trap_misal",  64'(misaligned), 64'(1));
        hold(10);

        // pc wraps from 0xFFC to 0 on a not-taken halting instruction.
        do_reset(1'b0, '0);
        run_instr(0, 0, 1'b0, 1'b1, 0, 32'h0000_0FFC, 1'b0);
        check("wrap_pre_pc", 64'(pc), 64'hFFC);
        run_instr(1, 1, 1'b1, 1'b0, 0, 32'h100, 1'b1);
        check("wrap_pc",     64'(pc),     64'h0);
        check("wrap_halted", 64'(halted), 64'(1));
        hold(5);

        // Fetching restarts from the reset pc.
        do_reset(1'b0, '0);
        check("restart_addr", 64'(imem_addr), 64'(0));
        check("restart_req",  64'(imem_req),  64'(1));
        run_instr(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle control FSM that owns the program counter and sequences each instruction through fetch, decode and execute. It issues instruction-memory requests through a req/ack handshake and holds the fetched word for the decoder. It waits for the execute stage to signal completion, then commits either the sequential PC (pc+4) or a branch/jump target. It sits between the instruction memory, decoder and ALU/comparator, and also reports a misaligned-target trap, a halt state and a retired-instruction count.

## Interface

Parameters:
- OPD_WIDTH, 32, operand/instruction width
- PC_WIDTH, 12, program counter width (byte address into instruction memory)
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_WIDTH  fetch address, equals pc
- imem_ack  in  1  fetch completion; imem_rdata valid in the same cycle
- imem_rdata  in  OPD_WIDTH  fetched instruction word
- instr  out  OPD_WIDTH  latched instruction, stable from DECODE until the next fetch completes
- instr_valid  out  1  one-cycle pulse in DECODE
- exec_done  in  1  execute stage has finished the current instruction
- branch  in  1  current instruction is a conditional branch
- jump  in  1  current instruction is an unconditional jump
- comp_result  in  OPD_WIDTH  comparator output; a branch is taken when it equals 1
- target  in  OPD_WIDTH  branch/jump target address from the ALU
- halt  in  1  stop after the current instruction
- pc  out  PC_WIDTH  current program counter
- pc_plus4  out  OPD_WIDTH  zero-extended pc + 4, combinational from pc
- instret  out  OPD_WIDTH  retired-instruction counter
- halted  out  1  high in HALTED state
- misaligned  out  1  high in TRAP state

## Operation

- The FSM has five states: FETCH, DECODE, EXEC, HALTED, TRAP.
- **Reset** forces the following values:
  - state = FETCH, pc = RESET_PC, instr = 0, instret = 0.
  - halted = 0, misaligned = 0, instr_valid = 0.
  - imem_req is 1 immediately after reset release, because it is decoded from the FETCH state.
- **FETCH**:
  - imem_req = 1, imem_addr = pc.
  - On imem_ack, instr <= imem_rdata and the FSM moves to DECODE.
  - Without imem_ack, the FSM stays in FETCH with req held high.
- **DECODE**: instr_valid = 1 for exactly one cycle, then unconditionally to EXEC.
- **EXEC**: waits for exec_done. In the exec_done cycle, branch, jump, comp_result, target and halt are sampled.
  - taken = jump | (branch & (comp_result == 1)), using a full-width compare.
  - **Taken with target[1:0] != 0:**
    - The FSM goes to TRAP.
    - pc and instret are unchanged.
  - **Taken with an aligned target:**
    - pc <= target[PC_WIDTH-1:0]; upper target bits are discarded.
    - instret <= instret + 1.
  - **Not taken:**
    - pc <= pc + 4, modulo 2^PC_WIDTH, so 0xFFC wraps to 0x000 for PC_WIDTH = 12.
    - instret <= instret + 1.
  - After a non-trap commit, the next state is HALTED if halt = 1, otherwise FETCH.
- **HALTED**: halted = 1; no requests, no state change until rst.
- **TRAP**: misaligned = 1; no requests, no state change until rst. Trap takes priority over halt.
- Ignored inputs:
  - imem_ack outside FETCH is ignored.
  - exec_done outside EXEC is ignored.
  - branch, jump and halt are ignored except in the exec_done cycle.
- instret wraps modulo 2^OPD_WIDTH.

## Timing

- Registered outputs: pc, instr, instret. State-decoded outputs (imem_req, instr_valid, halted, misaligned) change with the state register. pc_plus4 and imem_addr follow pc combinationally.
- Minimum cost is 3 cycles per instruction (FETCH with ack, DECODE, EXEC with exec_done). Each cycle imem_ack is late adds one cycle; each cycle exec_done is late adds one cycle.
- The new pc is visible on imem_addr in the first FETCH cycle after EXEC, i.e. one cycle after the exec_done edge.
- imem_req drops in the cycle after the ack edge; there is no back-to-back request.
- rst asserted mid-operation, including during a pending fetch, clears everything immediately without waiting for a clock edge. An outstanding ack after rst release is treated as a fresh ack for RESET_PC.

## Test plan

- **Reset:** RESET_PC=0, rst pulsed asynchronously between edges. Outputs clear before the next edge: pc=0, pc_plus4=4, instret=0, imem_req=1.
- **Sequential run:** imem_ack and exec_done always 1, no branch. pc steps 0, 4, 8, 12 every 3 cycles; instr_valid pulses once per instruction; instret=3 after the third EXEC.
- **Wait states:** imem_ack delayed 2 cycles and exec_done delayed 3 cycles. The instruction takes 8 cycles; imem_req stays high for 3 cycles; instr is latched only on the ack cycle.
- **Branch:** first instruction is branch=1, comp_result=1, target=0x40; the second is branch=1, comp_result=2, target=0x80. Results are pc=0x40, then pc=0x44; comp_result=2 counts as not taken.
- **Misaligned jump and halt:** jump=1 with target=0x42 and halt=1. The FSM enters TRAP with misaligned=1, pc unchanged, instret unchanged, halted=0, and imem_req stays 0 for 10 cycles.
- **Wrap and halt:** pc=0xFFC with a not-taken instruction and halt=1. pc becomes 0x000 and halted=1; after rst, fetching restarts at RESET_PC.
